ibuf_banked_queue: RTL and testbench

IBUF_BANKED_QUEUE -- requirements
Module: ibuf_banked_queue

---
 rtl/ibuf_banked_queue_pkg.sv | 21 ++
 rtl/ibuf_banked_queue_bank.sv | 33 +++
 rtl/ibuf_banked_queue.sv | 134 +++++++++++++
 tb/tb_ibuf_banked_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_banked_queue_pkg.sv
// Shared frontend definitions for the instruction buffer.
// Holds the instruction-entry layout carried through the buffer and the
// default geometry used by ibuf_banked_queue.
package ibuf_banked_queue_pkg;

    // One fetched instruction plus the fetch-side metadata travelling with it.
    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  fsq_idx;
        logic [4:0]  fsq_off;
        logic        page_fault;
        logic        access_fault;
    } ibuf_entry_t;

    localparam int IBUF_DATA_W   = 64;
    localparam int IBUF_BANKS    = 4;
    localparam int IBUF_DEPTH    = 16;
    localparam int IBUF_WR_WIDTH = 4;
    localparam int IBUF_RD_WIDTH = 4;

endpackage

// File: rtl/ibuf_banked_queue_bank.sv
// ibuf_bank: one storage bank of the instruction buffer.
// Ports:
//   clk    - clock; the write port updates on its rising edge
//   we     - write enable
//   waddr  - write row
//   wdata  - write data
//   raddr  - read row (asynchronous read)
//   rdata  - contents of row raddr
// Storage is deliberately not reset; occupancy is tracked by the owner.
module ibuf_bank #(
    parameter int DATA_W = 64,
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ibuf_banked_queue.sv
// ibuf_banked_queue: multi-ported instruction buffer built from BANKS
// single-write/single-read banks. Logical entry p lives in bank p mod BANKS,
// row p / BANKS, so any run of up to BANKS consecutive entries touches each
// bank at most once.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   flush     - discard all contents (frontend redirect)
//   in_valid  - enqueue request of in_num entries from in_data (slot 0 oldest)
//   in_ready  - at least WR_WIDTH entries free (from registered count only)
//   out_valid - prefix mask of presented entries
//   out_data  - entry head+k on slot k, combinational from registered state
//   out_take  - entries consumed this cycle
//   count     - occupied entries
module ibuf_banked_queue
    import ibuf_banked_queue_pkg::*;
#(
    parameter int DATA_W   = IBUF_DATA_W,
    parameter int BANKS    = IBUF_BANKS,
    parameter int DEPTH    = IBUF_DEPTH,
    parameter int WR_WIDTH = IBUF_WR_WIDTH,
    parameter int RD_WIDTH = IBUF_RD_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [$clog2(WR_WIDTH):0]      in_num,
    input  logic [WR_WIDTH*DATA_W-1:0]     in_data,
    output logic                           in_ready,
    output logic [RD_WIDTH-1:0]            out_valid,
    output logic [RD_WIDTH*DATA_W-1:0]     out_data,
    input  logic [$clog2(RD_WIDTH):0]      out_take,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int BW   = $clog2(BANKS);
    localparam int ROWS = DEPTH / BANKS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [RW-1:0]     wr_row      [BANKS];
    logic [RW-1:0]     rd_row      [BANKS];

    logic              enq;
    logic [DATA_W-1:0] slot_data   [BANKS];
    logic [BW-1:0]     wr_off      [BANKS];
    logic [BW-1:0]     rd_off      [BANKS];
    logic              bank_we     [BANKS];
    logic              bank_pop    [BANKS];
    logic [DATA_W-1:0] bank_wdata  [BANKS];
    logic [DATA_W-1:0] bank_rdata  [BANKS];
    logic [BW-1:0]     rd_sel      [RD_WIDTH];

    assign in_ready = (count <= CW'(DEPTH - WR_WIDTH));
    assign enq      = in_valid && in_ready && !flush;

    // Input slots padded out to BANKS so the crossbar index is always legal.
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_slot
        if (gi < WR_WIDTH) begin : g_live
            assign slot_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end else begin : g_pad
            assign slot_data[gi] = '0;
        end
    end

    // Write crossbar rotates by tail mod BANKS; read-pointer advance rotates
    // by head mod BANKS. A bank's offset from the pointer says which input
    // slot (or which dequeued entry) maps onto it this cycle.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            wr_off[b]     = BW'(b) - tail[BW-1:0];
            rd_off[b]     = BW'(b) - head[BW-1:0];
            bank_we[b]    = enq && (32'(wr_off[b]) < 32'(in_num));
            bank_pop[b]   = 32'(rd_off[b]) < 32'(out_take);
            bank_wdata[b] = slot_data[wr_off[b]];
        end
    end

    for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
        ibuf_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .ADDR_W (RW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[gb] && !rst),
            .waddr (wr_row[gb]),
            .wdata (bank_wdata[gb]),
            .raddr (rd_row[gb]),
            .rdata (bank_rdata[gb])
        );
    end

    // Output slot k reads the bank holding logical entry head+k.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int k = 0; k < RD_WIDTH; k++) begin
            rd_sel[k]                      = head[BW-1:0] + BW'(k);
            out_data[k*DATA_W +: DATA_W]   = bank_rdata[rd_sel[k]];
            out_valid[k]                   = 32'(count) > k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int b = 0; b < BANKS; b++) begin
                wr_row[b] <= '0;
                rd_row[b] <= '0;
            end
        end else begin
            if (enq) begin
                tail <= tail + PW'(in_num);
            end
            head  <= head + PW'(out_take);
            count <= count + (enq ? CW'(in_num) : CW'(0)) - CW'(out_take);
            for (int b = 0; b < BANKS; b++) begin
                if (bank_we[b]) begin
                    wr_row[b] <= wr_row[b] + RW'(1);
                end
                if (bank_pop[b]) begin
                    rd_row[b] <= rd_row[b] + RW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ibuf_banked_queue.sv
module tb_ibuf_banked_queue;

    localparam int DW = 32;
    localparam int D  = 16;
    localparam int WW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [2:0]   in_num;
    logic [127:0] in_data;
    logic         in_ready;
    logic [3:0]   out_valid;
    logic [127:0] out_data;
    logic [2:0]   out_take;
    logic [4:0]   count;

    always #5 clk = ~clk;

    ibuf_banked_queue #(
        .DATA_W   (32),
        .BANKS    (4),
        .DEPTH    (16),
        .WR_WIDTH (4),
        .RD_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_take  (out_take),
        .count     (count)
    );

    // Reference model: plain FIFO of entry values.
    logic [31:0] mq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        if (!rst) begin
            assert (32'(out_take) <= $countones(out_valid))
                else $error("illegal out_take %0d with out_valid %b", out_take, out_valid);
        end
    end

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v = '0;
        for (int k = 0; k < 4; k++) v[k] = (k < mq.size());
        return v;
    endfunction

    // One clock: drive, update model from pre-edge occupancy, sample #1 later.
    task automatic step(input bit v, input int num, input logic [127:0] d,
                        input int take, input bit fl, input bit rs);
        int pre;
        rst = rs; flush = fl; in_valid = v; in_num = 3'(num);
        in_data = d; out_take = 3'(take);
        pre = mq.size();
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < take; i++) void'(mq.pop_front());
            if (v && pre <= D - WW)
                for (int i = 0; i < num; i++) mq.push_back(d[i*DW +: DW]);
        end
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_num = '0; out_take = '0;
    endtask

    task automatic test_reset();
        step(0, 0, '0, 0, 0, 1);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        step(1, 3, pack4(32'h10, 32'h11, 32'h12, 32'hDEAD), 0, 0, 0);
        n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", count); end
        n_cmp++; if (out_valid !== 4'b0111) begin n_fail++; $display("FAIL basic_valid got %b want 0111", out_valid); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_data[k*DW +: DW] !== 32'h10 + 32'(k)) begin
                n_fail++; $display("FAIL basic_slot%0d got %h want %h", k, out_data[k*DW +: DW], 32'h10 + 32'(k));
            end
        end
    endtask

    task automatic test_full();
        step(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 4, pack4(32'h20 + 32'(4*i), 32'h21 + 32'(4*i), 32'h22 + 32'(4*i), 32'h23 + 32'(4*i)), 0, 0, 0);
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", in_ready); end
        step(1, 1, pack4(32'hFF, 32'hFF, 32'hFF, 32'hFF), 0, 0, 0);
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL drop_count got %0d want 16", count); end
        n_cmp++; if (out_data[31:0] !== 32'h20) begin n_fail++; $display("FAIL drop_head got %h want 20", out_data[31:0]); end
        n_cmp++; if (out_data[127:96] !== 32'h23) begin n_fail++; $display("FAIL drop_slot3 got %h want 23", out_data[127:96]); end
    endtask

    task automatic test_wrap();
        step(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4, pack4(1, 2, 3, 4), 0, 0, 0);
        step(1, 2, pack4(5, 6, 0, 0), 4, 0, 0);
        step(0, 0, '0, 4, 0, 0);
        step(0, 0, '0, 4, 0, 0);
        step(0, 0, '0, 2, 0, 0);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_drain got %0d want 0", count); end
        step(1, 4, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0, 0, 0);
        n_cmp++; if (out_data[63:0] !== {32'hA1, 32'hA0}) begin n_fail++; $display("FAIL wrap_take1 got %h want a1_a0", out_data[63:0]); end
        step(0, 0, '0, 2, 0, 0);
        n_cmp++; if (out_data[63:0] !== {32'hA3, 32'hA2}) begin n_fail++; $display("FAIL wrap_take2 got %h want a3_a2", out_data[63:0]); end
        n_cmp++; if (out_valid !== 4'b0011) begin n_fail++; $display("FAIL wrap_valid got %b want 0011", out_valid); end
        step(0, 0, '0, 2, 0, 0);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_simul();
        step(0, 0, '0, 0, 0, 1);
        step(1, 4, pack4(32'h30, 32'h31, 32'h32, 32'h33), 0, 0, 0);
        step(1, 1, pack4(32'h34, 0, 0, 0), 0, 0, 0);
        step(1, 4, pack4(32'h40, 32'h41, 32'h42, 32'h43), 2, 0, 0);
        n_cmp++; if (count !== 5'd7) begin n_fail++; $display("FAIL simul_count got %0d want 7", count); end
        n_cmp++; if (out_data[31:0] !== 32'h32) begin n_fail++; $display("FAIL simul_head got %h want 32", out_data[31:0]); end
    endtask

    task automatic test_flush();
        step(0, 0, '0, 0, 0, 1);
        step(1, 4, pack4(1, 2, 3, 4), 0, 0, 0);
        step(1, 4, pack4(5, 6, 7, 8), 0, 0, 0);
        step(1, 1, pack4(9, 0, 0, 0), 0, 0, 0);
        step(1, 4, pack4(32'hEE, 32'hEE, 32'hEE, 32'hEE), 3, 1, 0);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_valid got %b want 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", in_ready); end
        step(1, 1, pack4(32'h55, 0, 0, 0), 0, 0, 0);
        n_cmp++; if (out_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL flush_next got %h want 55", out_data[31:0]); end
    endtask

    task automatic test_rst_mid();
        step(0, 0, '0, 0, 0, 1);
        step(1, 4, pack4(1, 2, 3, 4), 0, 0, 0);
        step(1, 2, pack4(5, 6, 0, 0), 0, 0, 0);
        step(1, 4, pack4(7, 8, 9, 10), 0, 0, 1);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_valid got %b want 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        int sz, take, num;
        bit v, fl;
        step(0, 0, '0, 0, 0, 1);
        for (int c = 0; c < 500; c++) begin
            sz   = mq.size();
            v    = 1'($urandom_range(0, 3) != 0);
            num  = $urandom_range(1, 4);
            take = $urandom_range(0, (sz < 4) ? sz : 4);
            fl   = ($urandom_range(0, 39) == 0);
            step(v, v ? num : 0, {$urandom, $urandom, $urandom, $urandom}, take, fl, 0);
            n_cmp++; if (32'(count) !== mq.size()) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, mq.size()); end
            n_cmp++; if (in_ready !== (mq.size() <= D - WW)) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b", c, in_ready); end
            n_cmp++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", c, out_valid, exp_valid()); end
            for (int k = 0; k < 4; k++) begin
                if (k < mq.size()) begin
                    n_cmp++;
                    if (out_data[k*DW +: DW] !== mq[k]) begin
                        n_fail++; $display("FAIL rand_slot%0d cyc %0d got %h want %h", k, c, out_data[k*DW +: DW], mq[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_num = '0; in_data = '0; out_take = '0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_simul();
        test_flush();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
